// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: hilo_rwen encoding,
// FSM state encoding and the divider iteration count.
package hilo_unit_pkg;

    localparam int DATA_W = 32;

    // hilo_rwen bit positions
    localparam int RWEN_RD_HI = 3;
    localparam int RWEN_RD_LO = 2;
    localparam int RWEN_WR_HI = 1;
    localparam int RWEN_WR_LO = 0;

    // hilo_rwen codes as produced by the decoder
    localparam logic [3:0] RWEN_MULDIV = 4'b0011;
    localparam logic [3:0] RWEN_MTHI   = 4'b0010;
    localparam logic [3:0] RWEN_MTLO   = 4'b0001;

    localparam logic [5:0] DIV_LAST_CNT = 6'd31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DIV_FIX = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_unit_div_iter.sv
// Unsigned restoring divider core: one quotient bit per step, 32 steps.
// Operands are magnitudes; sign handling is done by the caller.
module div_iter
    import hilo_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              last
);

    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] diff;
    logic              fits;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        // Partial remainder shifted left with the next dividend bit brought in
        trial  = {rem_q, quo_q[DATA_W-1]};
        fits   = (trial >= {1'b0, dvsr_q});
        diff   = trial[DATA_W-1:0] - dvsr_q;
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvsr_d = divisor;
            cnt_d  = '0;
        end else if (step) begin
            rem_d = fits ? diff : trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], fits};
            cnt_d = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        quo_q  <= quo_d;
        rem_q  <= rem_d;
        dvsr_q <= dvsr_d;
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == DIV_LAST_CNT);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: single-cycle mult/mthi/mtlo, mfhi/mflo read port and a
// 34-cycle iterative divide that stalls the pipeline while it runs.
module hilo_unit
    import hilo_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [3:0]        hilo_rwen,
    input  logic              mul_sign,
    input  logic              div,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
        return n ? (~v + DATA_W'(1)) : v;
    endfunction

    hilo_state_e       state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              zero_q, zero_d;

    logic              act;
    logic              div_start, div_step, div_last;
    logic [DATA_W-1:0] div_quo, div_rem, mag_a, mag_b;
    logic signed [2*DATA_W-1:0] ext_a, ext_b, prod;

    assign act = in_valid & ~flush;

    // Low 64 bits of the product of the extended operands are exact for both signednesses
    assign ext_a = {{DATA_W{mul_sign & src_a[DATA_W-1]}}, src_a};
    assign ext_b = {{DATA_W{mul_sign & src_b[DATA_W-1]}}, src_b};
    assign prod  = ext_a * ext_b;

    assign mag_a = neg_if(src_a, mul_sign & src_a[DATA_W-1]);
    assign mag_b = neg_if(src_b, mul_sign & src_b[DATA_W-1]);

    div_iter u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        zero_d    = zero_q;
        stall     = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (act && hilo_rwen == RWEN_MULDIV) begin
                        if (div) begin
                            stall     = 1'b1;
                            div_start = 1'b1;
                            sign_a_d  = mul_sign & src_a[DATA_W-1];
                            sign_b_d  = mul_sign & src_b[DATA_W-1];
                            zero_d    = (src_b == '0);
                            state_d   = ST_DIV_RUN;
                        end else begin
                            {hi_d, lo_d} = prod;
                        end
                    end else if (act && hilo_rwen == RWEN_MTHI) begin
                        hi_d = src_a;
                    end else if (act && hilo_rwen == RWEN_MTLO) begin
                        lo_d = src_a;
                    end
                end
                ST_DIV_RUN: begin
                    stall    = 1'b1;
                    div_step = 1'b1;
                    if (div_last) begin
                        state_d = ST_DIV_FIX;
                    end
                end
                ST_DIV_FIX: begin
                    // Divide by zero returns all-ones quotient regardless of dividend sign
                    hi_d    = neg_if(div_rem, sign_a_q);
                    lo_d    = zero_q ? '1 : neg_if(div_quo, sign_a_q ^ sign_b_q);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (reset) begin
            stall = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (!reset) begin
            if (hilo_rwen[RWEN_RD_HI]) begin
                rdata = hi_q;
            end else if (hilo_rwen[RWEN_RD_LO]) begin
                rdata = lo_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
        zero_q   <= zero_d;
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: vector table, randomized mult/div against
// an arithmetic reference model, and flush/reset divide corner sequences.
module tb_hilo_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  hilo_rwen;
    logic        mul_sign;
    logic        div;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int nerr = 0;
    int nchk = 0;
    logic [31:0] ref_hi, ref_lo;

    hilo_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .hilo_rwen (hilo_rwen),
        .mul_sign  (mul_sign),
        .div       (div),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall     (stall),
        .rdata     (rdata),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        fl;
        logic [3:0]  rw;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_rdata;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rw, input logic sg, input logic dv,
                         input logic [31:0] a, input logic [31:0] b, input logic fl);
        in_valid  = v;
        hilo_rwen = rw;
        mul_sign  = sg;
        div       = dv;
        src_a     = a;
        src_b     = b;
        flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    // Returns {HI, LO} = {remainder, quotient}
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        int          sa, sb, sq, sr;
        int unsigned uq, ur;
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (sg) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            sa = $signed(a);
            sb = $signed(b);
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        drive(1'b1, 4'b0011, sg, 1'b1, a, b, 1'b0);
        #1;
        n = 0;
        while (stall && n < 40) begin
            n++;
            tick();
        end
        check({nm, "_stall_cycles"}, 32'(n), 32'd33);
        check({nm, "_hi_before"}, hi, ref_hi);
        check({nm, "_lo_before"}, lo, ref_lo);
        tick();
        idle();
        check({nm, "_hi"}, hi, ehi);
        check({nm, "_lo"}, lo, elo);
        ref_hi = ehi;
        ref_lo = elo;
    endtask

    initial begin
        logic [63:0] m;
        logic [31:0] ra, rb;
        logic        rs;

        vecs[0]  = '{1'b1, 1'b0, 4'b0011, 1'b1, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{1'b1, 1'b0, 4'b0010, 1'b0, 32'h12345678, 32'h0,        32'h0,        32'h12345678, 32'hFFFFFFFA};
        vecs[2]  = '{1'b1, 1'b0, 4'b1000, 1'b0, 32'h0,        32'h0,        32'h12345678, 32'h12345678, 32'hFFFFFFFA};
        vecs[3]  = '{1'b1, 1'b0, 4'b0001, 1'b0, 32'h0000BEEF, 32'h0,        32'h0,        32'h12345678, 32'h0000BEEF};
        vecs[4]  = '{1'b1, 1'b0, 4'b0100, 1'b0, 32'h0,        32'h0,        32'h0000BEEF, 32'h12345678, 32'h0000BEEF};
        vecs[5]  = '{1'b1, 1'b0, 4'b0011, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFE, 32'h00000001};
        vecs[6]  = '{1'b1, 1'b0, 4'b0011, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'h00000001};
        vecs[7]  = '{1'b1, 1'b0, 4'b0011, 1'b1, 32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 32'h00000000};
        vecs[8]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 32'hDEAD0000, 32'h0,        32'h0,        32'h40000000, 32'h00000000};
        vecs[9]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 32'h0BAD0000, 32'h0,        32'h0,        32'h40000000, 32'h00000000};
        vecs[10] = '{1'b1, 1'b0, 4'b1100, 1'b0, 32'h0,        32'h0,        32'h40000000, 32'h40000000, 32'h00000000};
        vecs[11] = '{1'b1, 1'b0, 4'b0011, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'h0,        32'hC0000000, 32'h80000000};

        // Reset behaviour
        reset = 1'b1;
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 32'd9, 32'd3, 1'b0);
        #1;
        check("reset_stall_divreq", {31'h0, stall}, 32'h0);
        tick();
        tick();
        hilo_rwen = 4'b1000;
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        reset = 1'b0;
        idle();
        tick();
        ref_hi = 32'h0;
        ref_lo = 32'h0;

        // Table-driven single-cycle operations
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].sg, 1'b0, vecs[i].a, vecs[i].b, vecs[i].fl);
            #1;
            check($sformatf("vec%0d_stall", i), {31'h0, stall}, 32'h0);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rdata);
            tick();
            check($sformatf("vec%0d_hi", i), hi, vecs[i].e_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].e_lo);
        end
        idle();
        ref_hi = 32'hC0000000;
        ref_lo = 32'h80000000;

        // Directed divides
        do_div("div_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_div("div_100_7", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
        do_div("div_5_0", 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFFFFFF);
        do_div("div_s5_0", 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFFFFFF);
        do_div("div_sm5_0", 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF);
        do_div("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000);

        // Randomized multiplies
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            m  = model_mul(ra, rb, rs);
            drive(1'b1, 4'b0011, rs, 1'b0, ra, rb, 1'b0);
            #1;
            check("rmul_stall", {31'h0, stall}, 32'h0);
            tick();
            check("rmul_hi", hi, m[63:32]);
            check("rmul_lo", lo, m[31:0]);
            ref_hi = m[63:32];
            ref_lo = m[31:0];
        end
        idle();

        // Randomized divides
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rs = 1'($urandom_range(0, 1));
            m  = model_div(ra, rb, rs);
            do_div("rdiv", ra, rb, rs, m[63:32], m[31:0]);
        end

        // Flush in DIV_RUN cycle 10
        drive(1'b1, 4'b0010, 1'b0, 1'b0, 32'hAAAA5555, 32'h0, 1'b0);
        tick();
        drive(1'b1, 4'b0001, 1'b0, 1'b0, 32'hAAAA5555, 32'h0, 1'b0);
        tick();
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 32'd100, 32'd7, 1'b0);
        tick();
        repeat (9) tick();
        check("flush_pre_stall", {31'h0, stall}, 32'h1);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();
        check("flush_idle_stall", {31'h0, stall}, 32'h0);
        check("flush_hi", hi, 32'hAAAA5555);
        check("flush_lo", lo, 32'hAAAA5555);
        repeat (30) tick();
        check("flush_hi_later", hi, 32'hAAAA5555);
        check("flush_lo_later", lo, 32'hAAAA5555);

        // Reset in DIV_RUN cycle 20
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 32'd100, 32'd7, 1'b0);
        tick();
        repeat (19) tick();
        check("rst_pre_stall", {31'h0, stall}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_stall_asserted", {31'h0, stall}, 32'h0);
        tick();
        reset = 1'b0;
        idle();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        ref_hi = 32'h0;
        ref_lo = 32'h0;
        do_div("div_9_3", 32'd9, 32'd3, 1'b0, 32'd0, 32'd3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, EX-stage instruction valid.
REQ-004 SHALL have port hilo_rwen, input, 4, bit3 read HI, bit2 read LO, bit1 write HI, bit0 write LO (decoder encoding).
REQ-005 SHALL have port mul_sign, input, 1, 1 = signed mult/div, 0 = unsigned.
REQ-006 SHALL have port div, input, 1, 1 = divide when hilo_rwen==4'b0011, 0 = multiply.
REQ-007 SHALL have ports src_a and src_b, input, 32 each, rs and rt operand values.
REQ-008 SHALL have port flush, input, 1, exception/eret cancel of the EX instruction.
REQ-009 SHALL have port stall, output, 1, hold EX and all upstream stages.
REQ-010 SHALL have port rdata, output, 32, mfhi/mflo result.
REQ-011 SHALL have ports hi and lo, output, 32 each, current HI and LO register values.

Function
REQ-012 SHALL define act = in_valid & ~flush; no HI/LO write occurs without act.
REQ-013 SHALL on act & rwen==0011 & ~div write the 64-bit product {HI,LO} = src_a*src_b (signed per mul_sign) at the same edge; stall stays 0.
REQ-014 SHALL on act & rwen==0010 write HI=src_a; on act & rwen==0001 write LO=src_a; no stall.
REQ-015 SHALL drive rdata = HI when rwen[3], LO when rwen[2], else 0; registered values only, no bypass.
REQ-016 SHALL implement states IDLE, DIV_RUN, DIV_FIX.
REQ-017 SHALL in IDLE with act & rwen==0011 & div: assert stall combinationally, capture operand magnitudes and signs, clear 6-bit counter, go to DIV_RUN.
REQ-018 SHALL in DIV_RUN perform one restoring quotient bit per cycle for exactly 32 cycles with stall=1, then go to DIV_FIX.
REQ-019 SHALL in DIV_FIX drive stall=0, apply signs (LO quotient negated if sign_a^sign_b, HI remainder negated if sign_a; signed only), write HI/LO at that edge, return to IDLE, and not start a new divide from the still-present request.
REQ-020 SHALL give divide latency 34 cycles from request to HI/LO update, with 33 stall cycles.
REQ-021 SHALL on divide by zero (src_b==0) produce LO=32'hFFFFFFFF and HI=src_a, signed and unsigned, with no exception and the same latency.
REQ-022 SHALL on 32'h80000000 / 32'hFFFFFFFF signed produce LO=32'h80000000 and HI=0.
REQ-023 SHALL on flush in any state drive stall=0 in that cycle, return to IDLE at the next edge, and leave HI/LO unchanged; a request in a flush cycle is not accepted.

Reset
REQ-024 SHALL on reset clear HI, LO and counter to 0 and enter IDLE at the next edge, including mid-divide.
REQ-025 SHALL drive stall=0 and rdata=0 while reset is asserted.

Structure
REQ-026 SHALL take state encodings and the hilo_rwen bit positions and codes from the shared defines header.
REQ-027 SHALL place the iterative magnitude divider (shift register, counter, restoring step) in sub-module div_iter; sign handling and HI/LO registers stay in hilo_unit.

Verification
REQ-028 SHALL test signed mult 32'hFFFFFFFE*32'h00000003 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFA next edge, stall never 1.
REQ-029 SHALL test signed div -7/2 -> stall 33 cycles, LO=32'hFFFFFFFD, HI=32'hFFFFFFFF at cycle 34; unsigned 100/7 -> LO=14, HI=2.
REQ-030 SHALL test div 5/0 -> LO=32'hFFFFFFFF, HI=5 after 34 cycles.
REQ-031 SHALL test mthi 32'h12345678 then mfhi next cycle -> rdata=32'h12345678, LO unchanged.
REQ-032 SHALL test flush at DIV_RUN cycle 10 of 100/7 with HI=LO=32'hAAAA5555 -> stall 0 that cycle, IDLE next, HI/LO still 32'hAAAA5555.
REQ-033 SHALL test reset at DIV_RUN cycle 20 -> HI=LO=0, IDLE and stall=0 next edge; a fresh 9/3 then yields LO=3, HI=0.
